// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PMAX_DEF = 3;

    function automatic int clog2(input int v);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) n = i + 1;
        end
        return n;
    endfunction

    localparam int CW_DEF = clog2(PMAX_DEF + 1);

endpackage

// File: rtl/regfile_pend_cnt.sv
// Saturating count of in-flight writes to one register, with the
// issue-accept and read-final qualifiers derived from it.
module regfile_pend_cnt
    import regfile_pkg::*;
#(
    parameter int PMAX   = PMAX_DEF,
    parameter int CW     = clog2(PMAX + 1),
    parameter int BYPASS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_busy,
    output logic o_iss_ready,
    output logic o_rd_ready
);

    logic [CW-1:0] r_cnt;
    logic          w_zero;
    logic          w_one;
    logic          w_full;

    assign w_zero = (r_cnt == '0);
    assign w_one  = (r_cnt == CW'(1));
    assign w_full = (r_cnt == CW'(PMAX));

    // Simultaneous issue and write-back cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!i_inc && i_dec && !w_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy      = !w_zero;
    assign o_iss_ready = !w_full || i_dec;
    assign o_rd_ready  = w_zero || ((BYPASS != 0) && w_one && i_dec);

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with per-register pending-write tracking
// and optional same-cycle write-to-read forwarding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int PMAX     = PMAX_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NREGS),
    localparam int CW      = clog2(PMAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    output logic [NREGS-1:0]    busy
);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NWR-1:0]   w_we;
    logic [NREGS-1:0] w_dec;
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_iss_rdy;
    logic [NREGS-1:0] w_rd_rdy;

    // Writes to a hard-wired zero register never happen at all.
    always_comb begin
        w_we = '0;
        for (int j = 0; j < NWR; j++) begin
            w_we[j] = wr_en[j] &&
                !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
        end
    end

    always_comb begin
        w_dec = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (w_we[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
                    w_dec[r] = 1'b1;
                end
            end
        end
    end

    assign iss_ready = w_iss_rdy[iss_rd];

    always_comb begin
        w_inc = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_inc[r] = iss_valid && iss_ready &&
                (iss_rd == AW'(r)) && !((ZERO_REG != 0) && (r == 0));
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        regfile_pend_cnt #(
            .PMAX   (PMAX),
            .CW     (CW),
            .BYPASS (BYPASS)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_inc       (w_inc[r]),
            .i_dec       (w_dec[r]),
            .o_busy      (w_busy[r]),
            .o_iss_ready (w_iss_rdy[r]),
            .o_rd_ready  (w_rd_rdy[r])
        );
    end

    assign busy = w_busy;

    // Ascending port order lets the highest-index writer win.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (w_we[j]) begin
                    r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k*XLEN +: XLEN] = r_mem[rd_addr[k*AW +: AW]];
            for (int j = 0; j < NWR; j++) begin
                if ((BYPASS != 0) && w_we[j] &&
                    (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0)) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end
            rd_ready[k] = w_rd_rdy[rd_addr[k*AW +: AW]];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed stimulus with a queue-based scoreboard for regfile_scoreboard.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra0, ra1, wa0, wa1, iss_rd;
    logic [31:0] wd0, wd1;
    logic [1:0]  wr_en;
    logic        iss_valid;
    logic [63:0] rdd;
    logic [1:0]  rd_ready;
    logic        iss_ready;
    logic [31:0] busy;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic [31:0] busy;
        logic        irdy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   ({ra1, ra0}),
        .rd_data   (rdd),
        .rd_ready  (rd_ready),
        .wr_en     (wr_en),
        .wr_addr   ({wa1, wa0}),
        .wr_data   ({wd1, wd0}),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .busy      (busy)
    );

    task automatic idle();
        rst       = 1'b0;
        ra0       = 5'd31;
        ra1       = 5'd31;
        wr_en     = 2'b00;
        wa0       = 5'd0;
        wa1       = 5'd0;
        wd0       = 32'h0;
        wd1       = 32'h0;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string n, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [1:0] rdy,
                              input logic [31:0] bsy, input logic irdy);
        exp_t e;
        e.name = n;
        e.d0   = d0;
        e.d1   = d1;
        e.rdy  = rdy;
        e.busy = bsy;
        e.irdy = irdy;
        q.push_back(e);
    endtask

    // Monitor: outputs are sampled mid-cycle, after the driver settled.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (rdd[31:0] !== e.d0 || rdd[63:32] !== e.d1 ||
                rd_ready !== e.rdy || busy !== e.busy ||
                iss_ready !== e.irdy) begin
                n_bad++;
                $display("FAIL %s: got d0=%h d1=%h rdy=%b busy=%h irdy=%b want d0=%h d1=%h rdy=%b busy=%h irdy=%b",
                         e.name, rdd[31:0], rdd[63:32], rd_ready, busy,
                         iss_ready, e.d0, e.d1, e.rdy, e.busy, e.irdy);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        wr_en = 2'b11; wa0 = 5'd1; wa1 = 5'd2;
        wd0 = 32'hDEAD; wd1 = 32'hBEEF;
        iss_valid = 1'b1; iss_rd = 5'd1;
        repeat (2) @(posedge clk);
        #1;
        idle();

        ra0 = 5'd1; ra1 = 5'd2;
        #1;
        n_cmp++;
        if (busy !== 32'h0 || iss_ready !== 1'b1 ||
            rd_ready !== 2'b11 || rdd !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_state: busy=%h irdy=%b rdy=%b rdd=%h",
                     busy, iss_ready, rd_ready, rdd);
        end

        for (int i = 0; i < 16; i++) begin
            ra0 = 5'(i);
            ra1 = 5'(i + 16);
            expect_out($sformatf("rst_rd%0d", i), 0, 0, 2'b11, 0, 1);
            cyc();
        end

        wr_en = 2'b01; wa0 = 5'd5; wd0 = 32'h1234; ra0 = 5'd5;
        expect_out("byp5", 32'h1234, 0, 2'b11, 0, 1);
        cyc();
        ra0 = 5'd5;
        expect_out("arr5", 32'h1234, 0, 2'b11, 0, 1);
        cyc();

        wr_en = 2'b11; wa0 = 5'd7; wa1 = 5'd7;
        wd0 = 32'hA; wd1 = 32'hB; ra0 = 5'd7; ra1 = 5'd5;
        expect_out("wr7both_byp", 32'hB, 32'h1234, 2'b11, 0, 1);
        cyc();
        ra0 = 5'd7;
        expect_out("wr7both_arr", 32'hB, 0, 2'b11, 0, 1);
        cyc();

        iss_valid = 1'b1; iss_rd = 5'd3; ra0 = 5'd3;
        expect_out("iss3a", 0, 0, 2'b11, 0, 1);
        cyc();
        iss_valid = 1'b1; iss_rd = 5'd3; ra0 = 5'd3;
        expect_out("iss3b", 0, 0, 2'b10, 32'h8, 1);
        cyc();
        iss_valid = 1'b1; iss_rd = 5'd3; ra0 = 5'd3;
        expect_out("iss3c", 0, 0, 2'b10, 32'h8, 1);
        cyc();
        iss_valid = 1'b1; iss_rd = 5'd3; ra0 = 5'd3;
        expect_out("iss3_full", 0, 0, 2'b10, 32'h8, 0);
        cyc();
        wr_en = 2'b01; wa0 = 5'd3; wd0 = 32'h33; ra0 = 5'd3; iss_rd = 5'd3;
        expect_out("wb3a", 32'h33, 0, 2'b10, 32'h8, 1);
        cyc();
        ra0 = 5'd3;
        expect_out("cnt3_two", 32'h33, 0, 2'b10, 32'h8, 1);
        cyc();
        wr_en = 2'b01; wa0 = 5'd3; wd0 = 32'h44; ra0 = 5'd3;
        expect_out("wb3b", 32'h44, 0, 2'b10, 32'h8, 1);
        cyc();
        wr_en = 2'b10; wa1 = 5'd3; wd1 = 32'h55; ra0 = 5'd3;
        expect_out("wb3c_byp_ready", 32'h55, 0, 2'b11, 32'h8, 1);
        cyc();
        ra0 = 5'd3;
        expect_out("free3", 32'h55, 0, 2'b11, 0, 1);
        cyc();

        iss_valid = 1'b1; iss_rd = 5'd4; ra0 = 5'd4;
        expect_out("iss4", 0, 0, 2'b11, 0, 1);
        cyc();
        iss_valid = 1'b1; iss_rd = 5'd4;
        wr_en = 2'b01; wa0 = 5'd4; wd0 = 32'h4; ra0 = 5'd4;
        expect_out("isswb4", 32'h4, 0, 2'b11, 32'h10, 1);
        cyc();
        ra0 = 5'd4;
        expect_out("hold4", 32'h4, 0, 2'b10, 32'h10, 1);
        cyc();

        wr_en = 2'b01; wa0 = 5'd0; wd0 = 32'hFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0; ra0 = 5'd0;
        expect_out("zero_byp", 0, 0, 2'b11, 32'h10, 1);
        cyc();
        ra0 = 5'd0;
        expect_out("zero_arr", 0, 0, 2'b11, 32'h10, 1);
        cyc();

        iss_valid = 1'b1; iss_rd = 5'd9;
        expect_out("iss9a", 0, 0, 2'b11, 32'h10, 1);
        cyc();
        iss_valid = 1'b1; iss_rd = 5'd9;
        expect_out("iss9b", 0, 0, 2'b11, 32'h210, 1);
        cyc();
        rst = 1'b1; iss_valid = 1'b1; iss_rd = 5'd9;
        wr_en = 2'b01; wa0 = 5'd9; wd0 = 32'h99; ra0 = 5'd7;
        expect_out("pre_rst", 32'hB, 0, 2'b11, 32'h210, 1);
        cyc();
        ra0 = 5'd7; ra1 = 5'd9;
        expect_out("post_rst", 0, 0, 2'b11, 0, 1);
        cyc();
        iss_valid = 1'b1; iss_rd = 5'd9; ra0 = 5'd9;
        expect_out("post_rst_iss", 0, 0, 2'b11, 0, 1);
        cyc();
        ra0 = 5'd9;
        expect_out("post_rst_cnt1", 0, 0, 2'b10, 32'h200, 1);
        cyc();

        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL wait_expired: %0d expectations never checked",
                     q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
